// File: rtl/conv2_dw_window_gen.sv
// -----------------------------------------------------------------------------
// conv2_dw_window_gen
//
// Streaming 3x3 window generator feeding the conv2 depthwise MAC stage.
// Pixels arrive one per valid cycle in raster order, all CH channels packed.
// Two line buffers hold the two previous rows; a 3x3 pixel shift register
// holds the current window. A packed window is emitted one cycle after every
// pixel that completes a full 3x3 neighbourhood (valid conv, stride 1).
//
// Window layout: element k = r*3+c (r=0 top/oldest row, c=0 leftmost column);
// channel ch, element k sits at window_act[ch*9*ACT_W + k*ACT_W +: ACT_W].
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   in_valid   in   in_pix valid this cycle
//   in_pix     in   one pixel, channel c at [c*ACT_W +: ACT_W]
//   sof        in   start-of-frame qualifier (only with CONV2_WINGEN_SOF_EN)
//   out_valid  out  window_act valid (depthwise stage valid)
//   window_act out  packed 3x3 window, all channels
//   frame_done out  pulse with the last window of a frame
//
// Optional feature macro: CONV2_WINGEN_SOF_EN (adds the sof input, which
// resynchronises the counters to row 0 / col 0 on the qualified pixel).
// -----------------------------------------------------------------------------
module conv2_dw_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CH    = 8,
  parameter int ACT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [CH*ACT_W-1:0]     in_pix,
`ifdef CONV2_WINGEN_SOF_EN
  input  logic                    sof,
`endif
  output logic                    out_valid,
  output logic [CH*9*ACT_W-1:0]   window_act,
  output logic                    frame_done
);

  localparam int PW = CH * ACT_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col_cnt;
  logic [RW-1:0] r_row_cnt;

  // lb1 holds row-1, lb0 holds row-2, indexed by column.
  logic [PW-1:0] r_lb0 [IMG_W];
  logic [PW-1:0] r_lb1 [IMG_W];

  // Window shift register, [row][col]; row 0 is the oldest row.
  logic [PW-1:0] r_win  [3][3];
  logic [PW-1:0] w_nwin [3][3];

  logic                  w_sof;
  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_row;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_emit;
  logic [CH*9*ACT_W-1:0] w_pack;

  // Effective position of the incoming pixel; a qualified sof forces 0/0.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_sof = 1'b0;
`ifdef CONV2_WINGEN_SOF_EN
    w_sof = in_valid && sof;
`endif
    w_col      = w_sof ? '0 : r_col_cnt;
    w_row      = w_sof ? '0 : r_row_cnt;
    w_col_last = (w_col == COL_LAST);
    w_row_last = (w_row == ROW_LAST);
    w_emit     = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
  end

  // Window after this pixel's column shifts in; packed straight into the
  // output layout so the emitted window matches the shift register state.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_nwin[r][0] = r_win[r][1];
      w_nwin[r][1] = r_win[r][2];
    end
    w_nwin[0][2] = r_lb0[w_col];
    w_nwin[1][2] = r_lb1[w_col];
    w_nwin[2][2] = in_pix;

    w_pack = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_pack[ch*9*ACT_W + (r*3+c)*ACT_W +: ACT_W] = w_nwin[r][c][ch*ACT_W +: ACT_W];
  end

  // NOTE: line-buffer RAM has no reset; rows 0/1 of every frame never emit,
  // so stale contents are always overwritten before they are used.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb0[w_col] <= r_lb1[w_col];
      r_lb1[w_col] <= in_pix;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      window_act <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else begin
      out_valid  <= w_emit;
      frame_done <= w_emit && w_col_last && w_row_last;
      if (w_emit)
        window_act <= w_pack;
      if (in_valid) begin
        r_win <= w_nwin;
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : w_row + RW'(1);
        end else begin
          r_col_cnt <= w_col + CW'(1);
          r_row_cnt <= w_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_dw_window_gen.sv
// -----------------------------------------------------------------------------
// Testbench for conv2_dw_window_gen (IMG_W=4, IMG_H=4, CH=8, ACT_W=8).
// Expected windows are computed from the frame contents and pushed to a
// scoreboard when the completing pixel is driven; a negedge monitor pops and
// compares window data, frame_done and the emission cycle.
// -----------------------------------------------------------------------------
module tb_conv2_dw_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CH = 8;
  localparam int AW = 8;
  localparam int PW = CH * AW;
  localparam int WW = CH * 9 * AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          sof = 1'b0;
  logic [PW-1:0] in_pix = '0;
  logic          out_valid;
  logic [WW-1:0] window_act;
  logic          frame_done;

  conv2_dw_window_gen #(.IMG_W(W), .IMG_H(H), .CH(CH), .ACT_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_pix     (in_pix),
`ifdef CONV2_WINGEN_SOF_EN
    .sof        (sof),
`endif
    .out_valid  (out_valid),
    .window_act (window_act),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] win;
    logic          fd;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [WW-1:0] rx_log[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] pix_val(int base, int n);
    logic [PW-1:0] v;
    v = '0;
    for (int ch = 0; ch < CH; ch++) v[ch*AW +: AW] = 8'((base + n + ch) % 256);
    return v;
  endfunction

  // Window for the pixel at (r, c) built directly from the pixel numbering.
  function automatic logic [WW-1:0] model_win(int base, int r, int c);
    logic [WW-1:0] w;
    int n;
    w = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++) begin
          n = (r - 2 + rr) * W + (c - 2 + cc);
          w[ch*9*AW + (rr*3+cc)*AW +: AW] = 8'((base + n + ch) % 256);
        end
    return w;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid) begin
        exp_t e;
        rx_log.push_back(window_act);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_window: out_valid=1 at cycle %0d with nothing expected", cyc);
        end else begin
          e = sb.pop_front();
          if (window_act !== e.win || frame_done !== e.fd || cyc !== e.cyc) begin
            bad++;
            $display("FAIL window: got win=%h fd=%b cyc=%0d, want win=%h fd=%b cyc=%0d",
                     window_act, frame_done, cyc, e.win, e.fd, e.cyc);
          end
        end
      end else if (frame_done !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL stray_frame_done: frame_done=%b without out_valid at cycle %0d", frame_done, cyc);
      end
    end
  end

  task automatic idle(int k);
    repeat (k) begin
      @(negedge clk);
      in_valid = 1'b0;
      sof      = 1'b0;
    end
  endtask

  task automatic send_pix(int base, int n, logic s, bit exp_en);
    int r, c;
    @(negedge clk);
    in_valid = 1'b1;
    in_pix   = pix_val(base, n);
    sof      = s;
    r = n / W;
    c = n % W;
    if (exp_en && r >= 2 && c >= 2)
      sb.push_back('{win: model_win(base, r, c), fd: (r == H-1 && c == W-1), cyc: cyc + 1});
  endtask

  task automatic send_frame(int base, int max_bubble, logic first_sof);
    for (int n = 0; n < W*H; n++) begin
      send_pix(base, n, (n == 0) ? first_sof : 1'b0, 1'b1);
      if (max_bubble > 0) idle($urandom_range(0, max_bubble));
    end
  endtask

  task automatic drain_check(string name, int exp_cnt);
    idle(6);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: %0d windows still expected, want 0", name, sb.size());
    end
    total++;
    if (rx_log.size() != exp_cnt) begin
      bad++;
      $display("FAIL %s_count: got %0d windows, want %0d", name, rx_log.size(), exp_cnt);
    end
    sb.delete();
  endtask

  task automatic check_outputs_zero(string name);
    total++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || window_act !== '0) begin
      bad++;
      $display("FAIL %s: out_valid=%b frame_done=%b window_act=%h, want all 0",
               name, out_valid, frame_done, window_act);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_continuous();
    logic [71:0] ch0;
    rx_log.delete();
    send_frame(0, 0, 1'b0);
    drain_check("continuous", 4);
    ch0 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    total++;
    if (rx_log.size() == 0 || rx_log[0][71:0] !== ch0) begin
      bad++;
      $display("FAIL continuous_first_ch0: got %h, want %h",
               (rx_log.size() != 0) ? rx_log[0][71:0] : 72'hx, ch0);
    end
  endtask

  task automatic test_bubbles();
    rx_log.delete();
    send_frame(0, 3, 1'b0);
    drain_check("bubbles", 4);
  endtask

  task automatic test_back_to_back();
    logic [71:0] ch0;
    rx_log.delete();
    send_frame(0, 0, 1'b0);
    send_frame(100, 0, 1'b0);
    drain_check("back_to_back", 8);
    ch0 = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
    total++;
    if (rx_log.size() < 5 || rx_log[4][71:0] !== ch0) begin
      bad++;
      $display("FAIL back_to_back_second_ch0: got %h, want %h",
               (rx_log.size() >= 5) ? rx_log[4][71:0] : 72'hx, ch0);
    end
  endtask

  task automatic test_mid_reset();
    rx_log.delete();
    for (int n = 0; n < 10; n++) send_pix(0, n, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    check_outputs_zero("mid_reset_outputs");
    @(negedge clk);
    check_outputs_zero("mid_reset_hold");
    rstn = 1'b1;
    sb.delete();
    send_frame(0, 0, 1'b0);
    drain_check("mid_reset", 4);
  endtask

  task automatic test_channels();
    logic [71:0] ch7;
    rx_log.delete();
    send_frame(0, 0, 1'b0);
    drain_check("channels", 4);
    ch7 = {8'd17, 8'd16, 8'd15, 8'd13, 8'd12, 8'd11, 8'd9, 8'd8, 8'd7};
    total++;
    if (rx_log.size() == 0 || rx_log[0][575:504] !== ch7) begin
      bad++;
      $display("FAIL channels_ch7: got %h, want %h",
               (rx_log.size() != 0) ? rx_log[0][575:504] : 72'hx, ch7);
    end
    total++;
    if (rx_log.size() == 0 || rx_log[0][3*72+64 +: 8] !== 8'd13) begin
      bad++;
      $display("FAIL channels_ch3_k8: got %0d, want 13",
               (rx_log.size() != 0) ? rx_log[0][3*72+64 +: 8] : 8'hx);
    end
  endtask

`ifdef CONV2_WINGEN_SOF_EN
  task automatic test_sof();
    rx_log.delete();
    for (int n = 0; n < 6; n++) send_pix(200, n, 1'b0, 1'b0);
    send_frame(0, 0, 1'b1);
    drain_check("sof", 4);
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    test_channels();
`ifdef CONV2_WINGEN_SOF_EN
    test_sof();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
